// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - funct codes decoded by the MDU (F_*)
//   - FSM state encoding (S_IDLE, S_ITER, S_FIX, S_DONE)
//   - quotient returned on divide-by-zero (DIV0_QUOT, sliced to DATA_W by users)
package mdu_pkg;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FIX,
    S_DONE
  } mdu_state_e;

  // All-ones quotient on divide-by-zero; wide enough for any DATA_W up to 64.
  localparam logic [63:0] DIV0_QUOT = '1;

endpackage

// File: rtl/restoring_div_step.sv
// restoring_div_step: one combinational iteration of unsigned restoring division.
//   i_rem  : partial remainder (always < i_dvsr between steps)
//   i_quo  : dividend bits still to be consumed (MSB first) / quotient bits so far
//   i_dvsr : divisor magnitude
//   o_rem  : updated partial remainder
//   o_quo  : quotient register shifted left with the new quotient bit in bit 0
module restoring_div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_rem,
  input  logic [DATA_W-1:0] i_quo,
  input  logic [DATA_W-1:0] i_dvsr,
  output logic [DATA_W-1:0] o_rem,
  output logic [DATA_W-1:0] o_quo
);

  logic [DATA_W:0] w_shift;
  logic [DATA_W:0] w_diff;

  // One extra bit: the shifted remainder may reach 2*divisor-1.
  assign w_shift = {i_rem, i_quo[DATA_W-1]};
  assign w_diff  = w_shift - {1'b0, i_dvsr};

  // Since the remainder stays below the divisor, the top bit of the
  // difference is set exactly when the trial subtraction underflows.
  always_comb begin
    if (!w_diff[DATA_W]) begin
      o_rem = w_diff[DATA_W-1:0];
      o_quo = {i_quo[DATA_W-2:0], 1'b1};
    end else begin
      o_rem = w_shift[DATA_W-1:0];
      o_quo = {i_quo[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit owning the HI/LO registers.
//   clk, reset         : clock, synchronous active-high reset
//   start, funct       : issue strobe and operation code
//   operando_1/2       : rs / rt operands, latched when an op is accepted
//   busy               : high while a MULT*/DIV* is iterating or being fixed up
//   done               : one-cycle pulse after HI/LO were written by MULT*/DIV*
//   hi, lo             : architectural HI/LO
//   result             : hi for MFHI, lo for MFLO, zero otherwise
// Build option: define MDU_FAST_MULT_EN for a single-cycle multiplier; division
// stays iterative either way.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] operando_1,
  input  logic [DATA_W-1:0] operando_2,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] result
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

`ifdef MDU_FAST_MULT_EN
  localparam mdu_state_e MUL_ENTRY = S_DONE;
`else
  localparam mdu_state_e MUL_ENTRY = S_ITER;
`endif

  mdu_state_e r_state, w_state_next;

  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_hi, r_lo;
  // Multiply: {partial product high, multiplier being shifted out}.
  // Divide:   {partial remainder, dividend shifting into quotient}.
  logic [2*DATA_W-1:0] r_acc;
  logic [DATA_W-1:0]   r_opa;      // multiplicand or divisor magnitude
  logic [DATA_W-1:0]   r_op1_raw;  // raw dividend, returned in HI on divide-by-zero
  logic                r_is_div;
  logic                r_neg_res;  // product / quotient must be negated
  logic                r_neg_rem;  // remainder takes the dividend's sign
  logic                r_div0;

  logic                w_accept;
  logic                w_is_mul, w_is_div, w_signed;
  logic                w_neg1, w_neg2;
  logic [DATA_W-1:0]   w_mag1, w_mag2;

  logic [DATA_W-1:0]   w_addend;
  logic [DATA_W:0]     w_mul_sum;
  logic [2*DATA_W-1:0] w_mul_next;
  logic [DATA_W-1:0]   w_rem_next, w_quo_next;

  logic [2*DATA_W-1:0] w_fix_prod;
  logic [DATA_W-1:0]   w_fix_quo, w_fix_rem;

  // ---------------------------------------------------------------------------
  // Issue decode
  // ---------------------------------------------------------------------------
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_is_mul = (funct == F_MULT) || (funct == F_MULTU);
  assign w_is_div = (funct == F_DIV) || (funct == F_DIVU);
  assign w_signed = (funct == F_MULT) || (funct == F_DIV);

  assign w_neg1 = w_signed && operando_1[DATA_W-1];
  assign w_neg2 = w_signed && operando_2[DATA_W-1];
  assign w_mag1 = w_neg1 ? -operando_1 : operando_1;
  assign w_mag2 = w_neg2 ? -operando_2 : operando_2;

`ifdef MDU_FAST_MULT_EN
  logic [2*DATA_W-1:0] w_ext1, w_ext2, w_fast_prod;

  // Low 2*DATA_W bits of the product of sign/zero-extended operands equal the
  // signed/unsigned full product.
  assign w_ext1      = {{DATA_W{w_neg1}}, operando_1};
  assign w_ext2      = {{DATA_W{w_neg2}}, operando_2};
  assign w_fast_prod = w_ext1 * w_ext2;
`endif

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  // Shift-add: add multiplicand to the upper half when the current multiplier
  // bit is set, then shift the whole accumulator right by one.
  assign w_addend   = r_acc[0] ? r_opa : '0;
  assign w_mul_sum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + {1'b0, w_addend};
  assign w_mul_next = {w_mul_sum, r_acc[DATA_W-1:1]};

  restoring_div_step #(
    .DATA_W (DATA_W)
  ) u_div_step (
    .i_rem  (r_acc[2*DATA_W-1:DATA_W]),
    .i_quo  (r_acc[DATA_W-1:0]),
    .i_dvsr (r_opa),
    .o_rem  (w_rem_next),
    .o_quo  (w_quo_next)
  );

  // Sign correction. The 0x80..0 / -1 overflow falls out naturally: the
  // magnitude quotient 0x80..0 negates to itself and the remainder is zero.
  assign w_fix_prod = r_neg_res ? -r_acc : r_acc;
  assign w_fix_quo  = r_neg_res ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
  assign w_fix_rem  = r_neg_rem ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        done         = (r_state == S_DONE);
        w_state_next = S_IDLE;
        if (start && w_is_div) begin
          w_state_next = S_ITER;
        end else if (start && w_is_mul) begin
          w_state_next = MUL_ENTRY;
        end
      end
      S_ITER: begin
        busy = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_state_next = S_FIX;
        end
      end
      S_FIX: begin
        busy         = 1'b1;
        w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and HI/LO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_acc     <= '0;
      r_opa     <= '0;
      r_op1_raw <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            case (funct)
              F_MTHI: r_hi <= operando_1;
              F_MTLO: r_lo <= operando_1;
              F_MULT, F_MULTU: begin
`ifdef MDU_FAST_MULT_EN
                {r_hi, r_lo} <= w_fast_prod;
`else
                r_is_div  <= 1'b0;
                r_opa     <= w_mag1;
                r_acc     <= {{DATA_W{1'b0}}, w_mag2};
                r_neg_res <= w_neg1 ^ w_neg2;
                r_cnt     <= '0;
`endif
              end
              F_DIV, F_DIVU: begin
                r_is_div  <= 1'b1;
                r_opa     <= w_mag2;
                r_acc     <= {{DATA_W{1'b0}}, w_mag1};
                r_neg_res <= w_neg1 ^ w_neg2;
                r_neg_rem <= w_neg1;
                r_div0    <= (operando_2 == '0);
                r_op1_raw <= operando_1;
                r_cnt     <= '0;
              end
              default: ;
            endcase
          end
        end
        S_ITER: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_is_div) begin
            r_acc <= {w_rem_next, w_quo_next};
          end else begin
            r_acc <= w_mul_next;
          end
        end
        S_FIX: begin
          if (!r_is_div) begin
            {r_hi, r_lo} <= w_fix_prod;
          end else if (r_div0) begin
            r_hi <= r_op1_raw;
            r_lo <= DIV0_QUOT[DATA_W-1:0];
          end else begin
            r_hi <= w_fix_rem;
            r_lo <= w_fix_quo;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

  always_comb begin
    result = '0;
    if (funct == F_MFHI) begin
      result = r_hi;
    end else if (funct == F_MFLO) begin
      result = r_lo;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  import mdu_pkg::*;

`ifdef MDU_FAST_MULT_EN
  localparam int MUL_LAT  = 1;
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_LAT  = 34;
  localparam int MUL_BUSY = 33;
`endif
  localparam int DIV_LAT  = 34;
  localparam int DIV_BUSY = 33;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] op1, op2;
  logic        busy, done;
  logic [31:0] hi, lo, result;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] sb_q[$];
  logic [63:0] mon_exp;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  mult_div_unit #(
    .DATA_W (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .funct      (funct),
    .operando_1 (op1),
    .operando_2 (op2),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .result     (result)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference model: {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      F_MULT:  return 64'(sa * sb);
      F_MULTU: return ua * ub;
      F_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      F_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return 64'b0;
    endcase
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_done: got done=1 at %0t, want no pulse", $time);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("hi_lo", {hi, lo}, mon_exp);
      end
    end
  end

  // Issue one MULT*/DIV*; optionally inject a start mid-op or reset at cycle k.
  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int inj_k, input logic [5:0] inj_f,
                        input logic [31:0] inj_a, input logic [31:0] inj_b, input int rst_k);
    logic [63:0] e;
    int bcnt, lat;
    bit got, aborted, is_mul;
    is_mul  = (f == F_MULT) || (f == F_MULTU);
    e       = ref_op(f, a, b);
    bcnt    = 0;
    lat     = 0;
    got     = 0;
    aborted = 0;
    sb_q.push_back(e);
    start = 1'b1;
    funct = f;
    op1   = a;
    op2   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op1   = $urandom;
    op2   = $urandom;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == rst_k) begin
        reset = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        chk({name, "_rst_busy"}, {63'b0, busy}, 64'd0);
        chk({name, "_rst_hilo"}, {hi, lo}, 64'd0);
        reset   = 1'b0;
        m_hi    = '0;
        m_lo    = '0;
        aborted = 1;
        break;
      end
      if (done === 1'b1) begin
        got = 1;
        lat = k;
        break;
      end
      if (busy === 1'b1) bcnt++;
      if (k == inj_k) begin
        start = 1'b1;
        funct = inj_f;
        op1   = inj_a;
        op2   = inj_b;
      end else if (k == inj_k + 1) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (!aborted) begin
      if (!got) begin
        n_vec++;
        n_err++;
        $display("FAIL %s_timeout: got no done in 100 cycles, want done", name);
      end else begin
        chk({name, "_lat"}, 64'(lat), 64'(is_mul ? MUL_LAT : DIV_LAT));
        chk({name, "_busy"}, 64'(bcnt), 64'(is_mul ? MUL_BUSY : DIV_BUSY));
        {m_hi, m_lo} = e;
      end
    end
  endtask

  task automatic run_simple(input string name, input logic [5:0] f, input logic [31:0] v);
    start = 1'b1;
    funct = f;
    op1   = v;
    op2   = $urandom;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (f == F_MTHI) m_hi = v;
    if (f == F_MTLO) m_lo = v;
    chk({name, "_hilo"}, {hi, lo}, {m_hi, m_lo});
    chk({name, "_busy"}, {63'b0, busy}, 64'd0);
    @(negedge clk);
    chk({name, "_done"}, {63'b0, done}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by 2ms, want finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] rf;
    logic [31:0] ra, rb;
    reset = 1'b1;
    start = 1'b0;
    funct = 6'b0;
    op1   = '0;
    op2   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_busy_done", {62'b0, busy, done}, 64'd0);
    chk("reset_result", {32'b0, result}, 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_op("mult_neg", F_MULT, 32'hFFFF_FFFD, 32'd5, 0, 6'b0, 0, 0, 0);
    run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, F_MULT, 32'd2, 32'd3, 0);
    run_op("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2, 0, 6'b0, 0, 0, 0);
    run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 6'b0, 0, 0, 0);
    run_op("divu_zero", F_DIVU, 32'd100, 32'd0, 0, 6'b0, 0, 0, 0);

    // MFHI / MFLO are pure reads, even with start asserted.
    funct = F_MFHI;
    start = 1'b1;
    #1;
    chk("mfhi_result", {32'b0, result}, {32'b0, m_hi});
    @(posedge clk);
    #1;
    funct = F_MFLO;
    #1;
    chk("mflo_result", {32'b0, result}, {32'b0, m_lo});
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("mf_nochange", {hi, lo}, {m_hi, m_lo});
    chk("mf_busy", {63'b0, busy}, 64'd0);

    run_simple("mthi_idle", F_MTHI, 32'h1234_5678);
    run_simple("mtlo_idle", F_MTLO, 32'hCAFE_F00D);
    run_simple("bad_funct", 6'b111111, 32'hDEAD_BEEF);

    run_op("div_mthi_ign", F_DIV, 32'd100, 32'd7, 5, F_MTHI, 32'h1234_5678, 0, 0);
    run_op("mult_rst", F_MULT, 32'h0001_2345, 32'h0000_0777, 0, 6'b0, 0, 0, 10);
    repeat (3) @(negedge clk);
    chk("post_rst_busy", {63'b0, busy}, 64'd0);
    run_op("divu_9_4", F_DIVU, 32'd9, 32'd4, 0, 6'b0, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0: rf = F_MULT;
        1: rf = F_MULTU;
        2: rf = F_DIV;
        default: rf = F_DIVU;
      endcase
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      if (i % 5 == 4) ra = 32'h8000_0000;
      run_op("rand", rf, ra, rb, 0, 6'b0, 0, 0, 0);
    end

    repeat (4) @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    chk("final_hilo", {hi, lo}, {m_hi, m_lo});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
